// File: rtl/pipe_pkg.sv
// pipe_pkg: shared stage-state type and occupancy encodings for pipeline stage registers
package pipe_pkg;
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } pipe_state_t;
   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_BUSY  = 2'd1;
   localparam logic [1:0] OCC_FULL  = 2'd2;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter; adds inc (0..3) when en, sticks at 2^W-1
// ports: clk, rst_n (async, active-low), en, inc[1:0], count[W-1:0]
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [1:0]   inc,
   output logic [W-1:0] count
);
   // two spare bits so count + 3 cannot wrap before the saturation test
   logic [W+1:0] sum;
   assign sum = {2'b00, count} + {{W{1'b0}}, inc};
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         count <= '0;
      else if (en)
         count <= (sum > {2'b00, {W{1'b1}}}) ? {W{1'b1}} : sum[W-1:0];
endmodule

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: valid/ready pipeline register with one-entry skid buffer, sync flush and flush-drop counter
// ports: clk, rst_n (async, active-low), flush_i, in_valid_i/in_ready_o/in_data_i upstream,
//        out_valid_o/out_ready_i/out_data_o downstream, occupancy_o (0..2), flush_drop_o
module pipe_skid_stage
   import pipe_pkg::*;
#(
   parameter int                DATA_W    = 64,
   parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
   parameter int                CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic [1:0]        occupancy_o,
   output logic [CNT_W-1:0]  flush_drop_o
);
   pipe_state_t       state_q, state_d;
   logic [DATA_W-1:0] main_q, skid_q;
   logic              acc, fire, main_ld, skid_ld;
   // ready/valid decode straight from the state flops: no path from out_ready_i to in_ready_o
   assign in_ready_o  = (state_q != FULL);
   assign out_valid_o = (state_q != EMPTY);
   assign out_data_o  = main_q;
   assign occupancy_o = (state_q == EMPTY) ? OCC_EMPTY : (state_q == BUSY) ? OCC_BUSY : OCC_FULL;
   assign acc  = in_valid_i & in_ready_o;
   assign fire = out_valid_o & out_ready_i;
   always_comb begin
      state_d = (state_q == EMPTY) ? (acc ? BUSY : EMPTY) :
                (state_q == BUSY)  ? ((acc && !fire) ? FULL : (!acc && fire) ? EMPTY : BUSY) :
                                     (fire ? BUSY : FULL);
      // main refills from skid when draining FULL, otherwise from the input on accept
      main_ld = (state_q == FULL) ? fire : acc & (fire | (state_q == EMPTY));
      skid_ld = acc & ~fire & (state_q == BUSY);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= EMPTY;
         main_q  <= FLUSH_VAL;
         skid_q  <= FLUSH_VAL;
      end else if (flush_i) begin
         state_q <= EMPTY;
         main_q  <= FLUSH_VAL;
         skid_q  <= FLUSH_VAL;
      end else begin
         state_q <= state_d;
         if (main_ld) main_q <= (state_q == FULL) ? skid_q : in_data_i;
         if (skid_ld) skid_q <= in_data_i;
      end
   // a flush discards everything held plus the beat accepted in the same cycle
   sat_counter #(.W(CNT_W)) u_drop (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (flush_i),
      .inc   (occupancy_o + {1'b0, acc}),
      .count (flush_drop_o)
   );
endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: directed + random checks of pipe_skid_stage against a queue-level reference model
module tb_pipe_skid_stage;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [63:0] in_data = '0;
   logic        in_ready, out_valid, in_ready2, out_valid2;
   logic [63:0] out_data, out_data2;
   logic [1:0]  occ, occ2;
   logic [15:0] drop;
   logic [1:0]  drop2;
   int          checks = 0;
   int          errors = 0;
   logic [63:0] q[$];
   logic [63:0] main_m = '0;
   int          cnt_m = 0;

   always #5 clk = ~clk;

   pipe_skid_stage dut (
      .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .in_data_i(in_data), .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
      .occupancy_o(occ), .flush_drop_o(drop)
   );
   pipe_skid_stage #(.CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready2),
      .in_data_i(in_data), .out_valid_o(out_valid2), .out_ready_i(out_ready), .out_data_o(out_data2),
      .occupancy_o(occ2), .flush_drop_o(drop2)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
      chk("out_data", out_data, main_m);
      chk("occupancy", 64'(occ), 64'(q.size()));
      chk("flush_drop", 64'(drop), 64'((cnt_m > 65535) ? 65535 : cnt_m));
      chk("flush_drop_w2", 64'(drop2), 64'((cnt_m > 3) ? 3 : cnt_m));
      chk("out_data_w2", out_data2, main_m);
      chk("occupancy_w2", 64'(occ2), 64'(q.size()));
   endtask

   // one clock: drive inputs, advance the model by the handshake rules, compare after the edge
   task automatic cyc(input logic v, input logic [63:0] d, input logic r, input logic f, output logic a);
      logic fi;
      in_valid = v; in_data = d; out_ready = r; flush = f;
      a  = v && (q.size() < 2);
      fi = (q.size() > 0) && r;
      @(posedge clk); #1;
      if (f) begin
         cnt_m += q.size() + int'(a);
         q.delete();
         main_m = '0;
      end else begin
         if (fi) void'(q.pop_front());
         if (a) q.push_back(d);
         if (q.size() > 0) main_m = q[0];
      end
      check_all();
   endtask

   initial begin
      logic a;
      logic pv;
      logic [63:0] pd;
      repeat (2) @(posedge clk);
      #1;
      check_all();
      rst_n = 1'b1;
      for (int i = 1; i <= 8; i++) cyc(1'b1, 64'(i), 1'b1, 1'b0, a);
      cyc(1'b0, '0, 1'b1, 1'b0, a);
      // stall for 3 cycles with the upstream holding its beat until accepted
      pd = 64'h11;
      cyc(1'b1, pd, 1'b1, 1'b0, a);
      pd = 64'h12;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, pd, 1'b0, 1'b0, a);
         if (a) pd = pd + 1;
      end
      chk("stall_occ", 64'(occ), 64'd2);
      chk("stall_ready", 64'(in_ready), 64'd0);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, pd, 1'b1, 1'b0, a);
         if (a) pd = pd + 1;
      end
      cyc(1'b0, '0, 1'b1, 1'b0, a);
      cyc(1'b0, '0, 1'b1, 1'b0, a);
      // FULL with 0xA,0xB then flush
      cyc(1'b1, 64'hA, 1'b0, 1'b0, a);
      cyc(1'b1, 64'hB, 1'b0, 1'b0, a);
      cyc(1'b0, '0, 1'b0, 1'b1, a);
      chk("flush_full_valid", 64'(out_valid), 64'd0);
      chk("flush_full_data", out_data, 64'd0);
      chk("flush_full_drop", 64'(drop), 64'd2);
      // BUSY plus accept of 0xC under flush
      cyc(1'b1, 64'h9, 1'b0, 1'b0, a);
      cyc(1'b1, 64'hC, 1'b0, 1'b1, a);
      chk("flush_busy_drop", 64'(drop), 64'd4);
      chk("flush_busy_sat", 64'(drop2), 64'd3);
      chk("flush_busy_occ", 64'(occ), 64'd0);
      // consecutive flushes only count accepted beats
      cyc(1'b1, 64'h33, 1'b1, 1'b1, a);
      cyc(1'b1, 64'h34, 1'b1, 1'b1, a);
      chk("flush_consec_drop", 64'(drop), 64'd6);
      // asynchronous reset while FULL
      cyc(1'b1, 64'h41, 1'b0, 1'b0, a);
      cyc(1'b1, 64'h42, 1'b0, 1'b0, a);
      in_valid = 1'b0; out_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      q.delete(); main_m = '0; cnt_m = 0;
      check_all();
      #2 rst_n = 1'b1;
      cyc(1'b1, 64'h55, 1'b0, 1'b0, a);
      chk("post_reset_valid", 64'(out_valid), 64'd1);
      chk("post_reset_data", out_data, 64'h55);
      // random traffic, upstream holds each beat until it is accepted
      pv = 1'b0; pd = '0;
      for (int i = 0; i < 600; i++) begin
         if (!pv) begin
            pv = ($urandom_range(0, 3) != 0);
            pd = {$urandom, $urandom};
         end
         cyc(pv, pd, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0), a);
         if (a || flush) pv = 1'b0;
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
